// File: rtl/capture_readout_ctrl_if.sv
// rtl/capture_readout_ctrl_if.sv - capture/readout control and stream signals with master/slave views
interface capture_readout_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 9
);
    logic              in_enable;
    logic              in_measure_sig;
    logic              in_sample_stb;
    logic [DATA_W-1:0] in_addata;
    logic              in_rd_ready;
    logic [DATA_W-1:0] out_rd_data;
    logic              out_rd_valid;
    logic              out_frame_busy;
    logic              out_frame_end;
    logic              out_overflow;
    logic [AW:0]       out_level;

    modport master (
        output in_enable, in_measure_sig, in_sample_stb, in_addata, in_rd_ready,
        input  out_rd_data, out_rd_valid, out_frame_busy, out_frame_end, out_overflow, out_level
    );

    modport slave (
        input  in_enable, in_measure_sig, in_sample_stb, in_addata, in_rd_ready,
        output out_rd_data, out_rd_valid, out_frame_busy, out_frame_end, out_overflow, out_level
    );
endinterface

// File: rtl/capture_readout_ctrl.sv
// rtl/capture_readout_ctrl.sv - buffers ADC samples during a measure window, then drains one frame downstream
module capture_readout_ctrl #(
    parameter int  DATA_W       = 8,
    parameter int  DEPTH        = 512,
    parameter int  READ_NUM     = 405,
    parameter int  FLUSH_ON_END = 1,
    localparam int AW           = $clog2(DEPTH)
) (
    input logic                    in_clk,
    input logic                    in_rst,
    capture_readout_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   READ_NUM_L = (AW+1)'(READ_NUM);
    localparam logic [AW:0]   LVL_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_dout_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       level_q;
    logic [AW:0]       frame_left_q;
    logic [1:0]        rd_wait_q;
    logic              meas_q;
    logic              rd_valid_q;
    logic              busy_q;
    logic              frame_end_q;
    logic              overflow_q;

    logic              full_d;
    logic              wr_en_d;
    logic              meas_fall_d;
    logic              xfer_d;
    logic [AW:0]       level_wr_d;

    always_comb begin
        full_d      = (level_q == DEPTH_L);
        wr_en_d     = bus.in_enable && (state_q == S_CAPTURE) && bus.in_sample_stb && !full_d;
        meas_fall_d = meas_q && !bus.in_measure_sig;
        xfer_d      = rd_valid_q && bus.in_rd_ready;
        level_wr_d  = wr_en_d ? level_q + LVL_ONE : level_q;
    end

    // Registered read port: data for rd_ptr_q appears one cycle after the pointer settles.
    always_ff @(posedge in_clk) begin
        if (wr_en_d) begin
            mem[wr_ptr_q] <= bus.in_addata;
        end
        ram_dout_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q      <= S_IDLE;
            rd_data_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_left_q <= '0;
            rd_wait_q    <= 2'd0;
            meas_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_end_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            meas_q      <= bus.in_measure_sig;
            frame_end_q <= 1'b0;
            if (!bus.in_enable) begin
                state_q    <= S_IDLE;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                level_q    <= '0;
                rd_wait_q  <= 2'd0;
                rd_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.in_measure_sig) begin
                            state_q    <= S_CAPTURE;
                            overflow_q <= 1'b0;
                        end
                    end
                    S_CAPTURE: begin
                        if (wr_en_d) begin
                            wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        end
                        if (bus.in_sample_stb && full_d) begin
                            overflow_q <= 1'b1;
                        end
                        level_q <= level_wr_d;
                        if (meas_fall_d) begin
                            if (level_wr_d != '0) begin
                                state_q      <= S_DRAIN;
                                busy_q       <= 1'b1;
                                rd_wait_q    <= 2'd2;
                                frame_left_q <= (level_wr_d < READ_NUM_L) ? level_wr_d : READ_NUM_L;
                            end else begin
                                state_q     <= S_DONE;
                                frame_end_q <= 1'b1;
                                if (FLUSH_ON_END != 0) begin
                                    wr_ptr_q <= '0;
                                    rd_ptr_q <= '0;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (xfer_d) begin
                            rd_valid_q   <= 1'b0;
                            rd_ptr_q     <= rd_ptr_q + PTR_ONE;
                            level_q      <= level_q - LVL_ONE;
                            frame_left_q <= frame_left_q - LVL_ONE;
                            if (frame_left_q == LVL_ONE) begin
                                state_q     <= S_DONE;
                                busy_q      <= 1'b0;
                                frame_end_q <= 1'b1;
                                if (FLUSH_ON_END != 0) begin
                                    wr_ptr_q <= '0;
                                    rd_ptr_q <= '0;
                                    level_q  <= '0;
                                end
                            end else begin
                                rd_wait_q <= 2'd2;
                            end
                        end else if (!rd_valid_q) begin
                            // Two-step fetch: pointer -> RAM register -> output register.
                            if (rd_wait_q == 2'd1) begin
                                rd_valid_q <= 1'b1;
                                rd_data_q  <= ram_dout_q;
                            end
                            if (rd_wait_q != 2'd0) begin
                                rd_wait_q <= rd_wait_q - 2'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out_rd_data    = rd_data_q;
    assign bus.out_rd_valid   = rd_valid_q;
    assign bus.out_frame_busy = busy_q;
    assign bus.out_frame_end  = frame_end_q;
    assign bus.out_overflow   = overflow_q;
    assign bus.out_level      = level_q;
endmodule
